// File: rtl/dino_jump_ctrl_if.sv
// dino_jump_ctrl_if: player inputs and dino height/status outputs of the jump controller
interface dino_jump_ctrl_if;
  logic       tick;
  logic       jump_pressed;
  logic       game_active;
  logic [7:0] dino_y;
  logic       airborne;
  logic       jump_start;
  modport master (output tick, jump_pressed, game_active, input dino_y, airborne, jump_start);
  modport slave (input tick, jump_pressed, game_active, output dino_y, airborne, jump_start);
endinterface

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: tick-stepped jump physics with variable-height jump cut and capped fall speed
module dino_jump_ctrl #(
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY  = 1,
  parameter int CUT_VEL  = 4,
  parameter int MAX_FALL = 12
) (
  input logic clk,
  input logic rst,
  dino_jump_ctrl_if.slave bus
);
  typedef enum logic [1:0] {GROUND, RISE, FALL, LAND} state_t;
  localparam logic signed [8:0] JV = 9'(JUMP_VEL);
  localparam logic signed [8:0] GR = 9'(GRAVITY);
  localparam logic signed [8:0] CV = 9'(CUT_VEL);
  localparam logic signed [8:0] MF = 9'(MAX_FALL);
  state_t state;
  logic signed [7:0] vel;
  logic prev, req;
  logic jump_edge, launch;
  logic signed [8:0] v_eff, rise_v, fall_v;
  logic signed [9:0] sum;
  assign jump_edge = bus.jump_pressed & ~prev;
  assign launch = bus.game_active && bus.tick && state == GROUND && (req || jump_edge);
  always_comb begin
    v_eff = (!bus.jump_pressed && 9'(vel) > CV) ? CV : 9'(vel);
    rise_v = v_eff - GR;
    fall_v = 9'(vel) - GR;
    sum = $signed({2'b00, bus.dino_y}) + 10'(state == RISE ? v_eff : 9'(vel));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= GROUND;
      vel <= '0;
      prev <= 1'b0;
      req <= 1'b0;
      bus.dino_y <= '0;
      bus.airborne <= 1'b0;
      bus.jump_start <= 1'b0;
    end else begin
      prev <= bus.jump_pressed;
      bus.jump_start <= launch;
      if (!bus.game_active) begin
        state <= GROUND;
        vel <= '0;
        req <= 1'b0;
        bus.dino_y <= '0;
        bus.airborne <= 1'b0;
      end else begin
        // presses are only remembered while standing; airborne/landing presses are dropped
        req <= state == GROUND && !launch && (req || jump_edge);
        if (bus.tick) begin
          case (state)
            GROUND: if (launch) begin
              state <= RISE;
              bus.airborne <= 1'b1;
              bus.dino_y <= JV[7:0];
              vel <= 8'(JV - GR);
            end
            RISE: begin
              bus.dino_y <= sum > 10'sd255 ? 8'hff : sum[7:0];
              vel <= rise_v[7:0];
              if (rise_v <= 0) state <= FALL;
            end
            FALL: if (sum <= 0) begin
              state <= LAND;
              bus.airborne <= 1'b0;
              bus.dino_y <= '0;
              vel <= '0;
            end else begin
              bus.dino_y <= sum[7:0];
              vel <= fall_v < -MF ? 8'(-MF) : fall_v[7:0];
            end
            default: state <= GROUND;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb_dino_jump_ctrl: directed jump scenarios against hand-computed height tables
module tb_dino_jump_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  dino_jump_ctrl_if bus ();
  dino_jump_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_tick();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask
  task automatic idle();
    @(negedge clk);
  endtask
  task automatic chk_out(input string tag, input int y, input int air, input int js);
    chk({tag, ".y"}, int'(bus.dino_y), y);
    chk({tag, ".air"}, int'(bus.airborne), air);
    chk({tag, ".js"}, int'(bus.jump_start), js);
  endtask
  int rise_tbl[12] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78};
  int fall_tbl[13] = '{78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
  int hop_tbl[11] = '{16, 19, 21, 22, 22, 21, 19, 16, 12, 7, 1};
  initial begin
    bus.tick = 1'b0;
    bus.jump_pressed = 1'b0;
    bus.game_active = 1'b1;
    idle();
    idle();
    chk_out("reset", 0, 0, 0);
    rst = 1'b1;
    idle();
    // edge and tick together launch immediately
    bus.jump_pressed = 1'b1;
    do_tick();
    chk_out("launch", 12, 1, 1);
    idle();
    chk("launch_pulse_end", int'(bus.jump_start), 0);
    for (int i = 1; i < 12; i++) begin
      do_tick();
      chk($sformatf("rise%0d", i), int'(bus.dino_y), rise_tbl[i]);
    end
    chk("apex_air", int'(bus.airborne), 1);
    for (int i = 0; i < 13; i++) begin
      do_tick();
      chk($sformatf("fall%0d", i), int'(bus.dino_y), fall_tbl[i]);
      chk($sformatf("fall_air%0d", i), int'(bus.airborne), i < 12 ? 1 : 0);
    end
    // new edge while landing must be dropped
    bus.jump_pressed = 1'b0;
    idle();
    bus.jump_pressed = 1'b1;
    idle();
    do_tick();
    chk_out("land_to_ground", 0, 0, 0);
    do_tick();
    chk_out("no_land_relaunch", 0, 0, 0);
    do_tick();
    chk_out("held_no_jump", 0, 0, 0);
    // edge without tick is buffered until the next tick
    bus.jump_pressed = 1'b0;
    idle();
    bus.jump_pressed = 1'b1;
    idle();
    idle();
    chk_out("buffered_wait", 0, 0, 0);
    do_tick();
    chk_out("buffered_launch", 12, 1, 1);
    bus.jump_pressed = 1'b0;
    for (int i = 0; i < 11; i++) begin
      do_tick();
      chk($sformatf("hop%0d", i), int'(bus.dino_y), hop_tbl[i]);
      chk($sformatf("hop_js%0d", i), int'(bus.jump_start), 0);
      if (i == 0) bus.jump_pressed = 1'b1;
    end
    do_tick();
    chk_out("hop_land", 0, 0, 0);
    do_tick();
    do_tick();
    chk_out("hop_no_relaunch", 0, 0, 0);
    // async reset mid-rise
    bus.jump_pressed = 1'b0;
    idle();
    bus.jump_pressed = 1'b1;
    for (int i = 0; i < 5; i++) do_tick();
    chk("pre_reset_y", int'(bus.dino_y), 50);
    #2 rst = 1'b0;
    #1 chk_out("async_reset", 0, 0, 0);
    idle();
    rst = 1'b1;
    idle();
    do_tick();
    chk_out("held_after_reset", 12, 1, 1);
    for (int i = 1; i < 14; i++) do_tick();
    chk("mid_fall_y", int'(bus.dino_y), 77);
    chk("mid_fall_air", int'(bus.airborne), 1);
    bus.game_active = 1'b0;
    idle();
    chk_out("game_off", 0, 0, 0);
    bus.game_active = 1'b1;
    do_tick();
    chk_out("game_on_no_edge", 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end
endmodule

// File: doc/dino_jump_ctrl.md
DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

Interface
REQ-001 Parameter JUMP_VEL, default 12: initial upward velocity in height units per tick.
REQ-002 Parameter GRAVITY, default 1: velocity decrement applied per tick while airborne.
REQ-003 Parameter CUT_VEL, default 4: maximum upward velocity once jump_pressed is released during rise.
REQ-004 Parameter MAX_FALL, default 12: maximum downward speed magnitude.
REQ-005 clk  input  1  system clock; one clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 tick  input  1  frame-step enable, one-cycle pulse; physics advances only on cycles with tick=1.
REQ-008 jump_pressed  input  1  debounced jump level from the input handler.
REQ-009 game_active  input  1  high while the game runs; low forces the dino to the ground.
REQ-010 dino_y  output  8  registered unsigned height above ground; 0 means on ground.
REQ-011 airborne  output  1  registered; high in RISE or FALL.
REQ-012 jump_start  output  1  registered one-cycle pulse on the cycle after a jump launches.

Function
REQ-013 States: GROUND, RISE, FALL, LAND. Internal velocity: signed 8-bit.
REQ-014 Edge detection: register the previous jump_pressed value; edge = jump_pressed & ~prev. A held level never produces a second edge.
REQ-015 Request flag: set on an edge while in GROUND with game_active=1; ignored in RISE, FALL and LAND (no buffering of airborne presses); cleared when consumed or when leaving GROUND.
REQ-016 GROUND with tick=1 and (request or edge in the same cycle): go to RISE, vel=JUMP_VEL-GRAVITY, dino_y=JUMP_VEL, jump_start=1 for the next cycle.
REQ-017 RISE on tick: v_eff = CUT_VEL if (jump_pressed=0 and vel>CUT_VEL), else vel; dino_y <= dino_y+v_eff saturated at 255; vel <= v_eff-GRAVITY; go to FALL when v_eff-GRAVITY <= 0.
REQ-018 FALL on tick: if dino_y+vel <= 0, then dino_y=0, vel=0 and go to LAND; else dino_y <= dino_y+vel and vel <= max(vel-GRAVITY, -MAX_FALL).
REQ-019 LAND on tick: go to GROUND; edges seen in LAND are discarded.
REQ-020 Between ticks, state, dino_y and vel hold; only edge capture and the request flag update.
REQ-021 game_active=0 on any cycle: next state GROUND, dino_y=0, vel=0, request cleared, jump_start=0; this takes priority over tick.
REQ-022 airborne is registered together with state and equals (state==RISE or state==FALL).

Reset
REQ-023 rst=0 asynchronously forces state GROUND, dino_y=0, vel=0, airborne=0, jump_start=0, request=0 and prev=0, including mid-jump.
REQ-024 After rst deasserts, a jump_pressed level already high counts as an edge on the first clock.

Verification (defaults)
REQ-025 Full jump, jump_pressed held: dino_y after successive ticks is 12,23,33,42,50,57,63,68,72,75,77,78; the 12th tick enters FALL; fall gives 78,77,75,72,68,63,57,50,42,33,23,12,0; then LAND, then GROUND on the next tick.
REQ-026 Short hop: release after the first tick (y=12). Next ticks give 16,19,21,22, then FALL.
REQ-027 Edge and tick in the same cycle while in GROUND: launch on that tick; jump_start is high exactly one cycle; airborne rises in the same cycle.
REQ-028 Press again during RISE and during LAND: no relaunch; after landing, no jump occurs until a new edge.
REQ-029 rst pulsed low at y=50 mid-rise: dino_y=0 and airborne=0 immediately, without a clock; game_active dropped mid-fall gives GROUND and y=0 on the next clock.
